// File: rtl/display_serial_scheduler.sv
// Serial load scheduler for the 4-digit bi-colour seven-segment display.
// Round-robin between frame and brightness words, then shifts and strobes.
module display_serial_scheduler #(
   parameter int FRAME_BITS  = 96,
   parameter int BRIGHT_BITS = 12,
   parameter int CLK_DIV     = 2,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   frame_valid,
   input  logic [FRAME_BITS-1:0]  frame_data,
   output logic                   frame_ready,
   input  logic                   bright_valid,
   input  logic [BRIGHT_BITS-1:0] bright_data,
   output logic                   bright_ready,
   output logic                   sclk,
   output logic                   sdata,
   output logic                   slatch,
   output logic                   spwm,
   output logic                   busy,
   output logic                   done
);

   localparam int CMAX = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = $clog2(FRAME_BITS + 1);
   localparam int PADW = FRAME_BITS - BRIGHT_BITS;

   localparam logic [CW-1:0] PH1     = CW'(CLK_DIV);
   localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
   localparam logic [BW-1:0] ONE     = BW'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      STROBE,
      GAP
   } state_t;

   state_t                state;
   state_t                state_n;
   logic [FRAME_BITS-1:0] sreg;
   logic [BW-1:0]         bcnt;
   logic [CW-1:0]         cnt;
   logic                  is_frame;
   logic                  last_frame;
   logic                  idle;
   logic                  f_win;
   logic                  b_win;
   logic                  f_acc;
   logic                  b_acc;

   // a lone requester always wins; a contest goes to the class not served last
   assign idle         = (state == IDLE);
   assign f_win        = bright_valid ? (frame_valid & ~last_frame) : 1'b1;
   assign b_win        = frame_valid ? (bright_valid & last_frame) : 1'b1;
   assign frame_ready  = idle & f_win;
   assign bright_ready = idle & b_win;
   assign f_acc        = frame_valid & frame_ready;
   assign b_acc        = bright_valid & bright_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      sclk    = 1'b0;
      sdata   = 1'b0;
      slatch  = 1'b0;
      spwm    = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (f_acc | b_acc) state_n = SHIFT;
         end
         SHIFT: begin
            sclk  = (cnt >= PH1);
            sdata = sreg[FRAME_BITS-1];
            if (cnt == BIT_END && bcnt == ONE) state_n = STROBE;
         end
         STROBE: begin
            slatch = is_frame;
            spwm   = ~is_frame;
            if (cnt == BIT_END) state_n = GAP;
         end
         GAP: begin
            if (cnt == GAP_END) begin
               done    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg       <= '0;
         bcnt       <= '0;
         cnt        <= '0;
         is_frame   <= 1'b0;
         last_frame <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (f_acc) begin
                  sreg       <= frame_data;
                  bcnt       <= BW'(FRAME_BITS);
                  is_frame   <= 1'b1;
                  last_frame <= 1'b1;
               end else if (b_acc) begin
                  sreg       <= {bright_data, {PADW{1'b0}}};
                  bcnt       <= BW'(BRIGHT_BITS);
                  is_frame   <= 1'b0;
                  last_frame <= 1'b0;
               end
            end
            SHIFT: begin
               if (cnt == BIT_END) begin
                  cnt  <= '0;
                  sreg <= {sreg[FRAME_BITS-2:0], 1'b0};
                  bcnt <= bcnt - ONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STROBE: begin
               if (cnt == BIT_END) cnt <= '0;
               else cnt <= cnt + 1'b1;
            end
            GAP: begin
               if (cnt == GAP_END) cnt <= '0;
               else cnt <= cnt + 1'b1;
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule
